// File: rtl/display_feeder.sv
// display_feeder: debounced page selector feeding a 32-bit word to a 7-seg scanner.
// Ports: clk, rst (async low), btn_next, hold, src0..src3 in; data, page, banner out.
module display_feeder #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter int unsigned BANNER_CYCLES   = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        hold,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] src3,
  output logic [31:0] data,
  output logic [1:0]  page,
  output logic        banner
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BANNER_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BN_LOAD = BW'(BANNER_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_e;

  logic            btn_s1_q, btn_s2_q;
  logic            hold_s1_q, hold_s2_q;
  logic [1:0]      vld_q, vld_d;
  logic            armed_q, armed_d;
  db_state_e       state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic            next_pulse;
  logic            take;
  logic [1:0]      page_q, page_d;
  logic            banner_q, banner_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [31:0]     data_q, data_d;
  logic [31:0]     src_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1_q  <= 1'b0;
      btn_s2_q  <= 1'b0;
      hold_s1_q <= 1'b0;
      hold_s2_q <= 1'b0;
    end else begin
      btn_s1_q  <= btn_next;
      btn_s2_q  <= btn_s1_q;
      hold_s1_q <= hold;
      hold_s2_q <= hold_s1_q;
    end
  end

  // The synchronizer shows reset zeros for two cycles; only a real
  // released sample after that arms the debouncer, so a button held
  // through reset never produces a step.
  always_comb begin
    vld_d   = {vld_q[0], 1'b1};
    armed_d = armed_q | (vld_q[1] & ~btn_s2_q);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    next_pulse = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (btn_s2_q && armed_q) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!btn_s2_q) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d    = PRESSED;
          next_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      PRESSED: begin
        if (!btn_s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s2_q) begin
          state_d = PRESSED;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (page_q)
      2'd0:    src_sel = src0;
      2'd1:    src_sel = src1;
      2'd2:    src_sel = src2;
      default: src_sel = src3;
    endcase
  end

  // Banner word uses next-cycle page so it lines up with banner.
  always_comb begin
    take     = next_pulse & ~hold_s2_q;
    page_d   = page_q;
    banner_d = banner_q;
    bcnt_d   = bcnt_q;
    if (take) begin
      page_d   = page_q + 2'd1;
      banner_d = 1'b1;
      bcnt_d   = BN_LOAD;
    end else if (banner_q) begin
      if (bcnt_q == '0) banner_d = 1'b0;
      else              bcnt_d   = bcnt_q - BW'(1);
    end
    if (banner_d)       data_d = {28'hFFF_FFFF, 2'b00, page_d};
    else if (hold_s2_q) data_d = data_q;
    else                data_d = src_sel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q    <= '0;
      armed_q  <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      page_q   <= '0;
      banner_q <= 1'b0;
      bcnt_q   <= '0;
      data_q   <= '0;
    end else begin
      vld_q    <= vld_d;
      armed_q  <= armed_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      page_q   <= page_d;
      banner_q <= banner_d;
      bcnt_q   <= bcnt_d;
      data_q   <= data_d;
    end
  end

  assign data   = data_q;
  assign page   = page_q;
  assign banner = banner_q;

endmodule

// File: tb/tb_display_feeder.sv
// tb_display_feeder: directed checks of display_feeder (DEBOUNCE=4, BANNER=8).
// A second instance with a longer banner covers a re-press inside the banner.
module tb_display_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_next = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] src0, src1, src2, src3;
  logic [31:0] data, data2;
  logic [1:0]  page, page2;
  logic        banner, banner2;
  logic [31:0] sv [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  display_feeder #(.DEBOUNCE_CYCLES(4), .BANNER_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .hold(hold),
    .src0(src0), .src1(src1), .src2(src2), .src3(src3),
    .data(data), .page(page), .banner(banner)
  );

  display_feeder #(.DEBOUNCE_CYCLES(4), .BANNER_CYCLES(24)) u_dut2 (
    .clk(clk), .rst(rst), .btn_next(btn_next), .hold(hold),
    .src0(src0), .src1(src1), .src2(src2), .src3(src3),
    .data(data2), .page(page2), .banner(banner2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_release();
    btn_next = 1'b1;
    repeat (7) tick();
    btn_next = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_reset();
    src0 = 32'h1234_5678; src1 = 32'h1111_0001;
    src2 = 32'h2222_0002; src3 = 32'h3333_0003;
    sv[0] = 32'h1234_5678; sv[1] = 32'h1111_0001;
    sv[2] = 32'h2222_0002; sv[3] = 32'h3333_0003;
    rst = 1'b0;
    #3;
    n_tests++;
    if (data !== 32'h0 || page !== 2'd0 || banner !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals: data=%h page=%0d banner=%b want 0/0/0",
               data, page, banner);
    end
    tick();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL reset_src0: data=%h want 12345678", data);
    end
    n_tests++;
    if (page !== 2'd0 || banner !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_page: page=%0d banner=%b want 0/0", page, banner);
    end
  endtask

  task automatic test_bounce();
    int steps = 0;
    int nb = 0;
    int bad = 0;
    logic [1:0] prev;
    logic [0:7] pat;
    prev = page;
    pat = 8'b1100_1100;
    for (int i = 0; i < 28; i++) begin
      btn_next = (i < 8) ? pat[i] : 1'b1;
      tick();
      if (page !== prev) steps++;
      prev = page;
      if (banner === 1'b1) begin
        nb++;
        if (data !== {28'hFFF_FFFF, 2'b00, page}) bad++;
      end
    end
    n_tests++;
    if (steps != 1 || page !== 2'd1) begin
      n_fail++;
      $display("FAIL bounce_step: steps=%0d page=%0d want 1/1", steps, page);
    end
    n_tests++;
    if (nb != 8 || bad != 0) begin
      n_fail++;
      $display("FAIL bounce_banner: cycles=%0d badword=%0d want 8/0", nb, bad);
    end
    n_tests++;
    if (data !== 32'h1111_0001) begin
      n_fail++;
      $display("FAIL bounce_data: data=%h want 11110001", data);
    end
    btn_next = 1'b0;
    repeat (15) tick();
  endtask

  task automatic test_latency();
    btn_next = 1'b1;
    repeat (6) tick();
    n_tests++;
    if (page !== 2'd1) begin
      n_fail++;
      $display("FAIL lat_early: page=%0d want 1", page);
    end
    tick();
    n_tests++;
    if (page !== 2'd2 || banner !== 1'b1 || data !== 32'hFFFF_FFF2) begin
      n_fail++;
      $display("FAIL lat_step: page=%0d banner=%b data=%h want 2/1/FFFFFFF2",
               page, banner, data);
    end
    btn_next = 1'b0;
    repeat (20) tick();
    n_tests++;
    if (data !== 32'h2222_0002) begin
      n_fail++;
      $display("FAIL lat_data: data=%h want 22220002", data);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp;
    press_release();
    n_tests++;
    if (page !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_pre: page=%0d want 3", page);
    end
    for (int i = 0; i < 4; i++) begin
      exp = 2'(i);
      btn_next = 1'b1;
      repeat (7) tick();
      n_tests++;
      if (page !== exp || data !== {28'hFFF_FFFF, 2'b00, exp}) begin
        n_fail++;
        $display("FAIL wrap_banner%0d: page=%0d data=%h want %0d", i,
                 page, data, exp);
      end
      btn_next = 1'b0;
      repeat (20) tick();
      n_tests++;
      if (page !== exp || data !== sv[i]) begin
        n_fail++;
        $display("FAIL wrap_src%0d: page=%0d data=%h want %0d/%h", i,
                 page, data, exp, sv[i]);
      end
    end
  endtask

  task automatic test_hold();
    press_release();
    hold = 1'b1;
    repeat (3) tick();
    src0 = 32'hDEAD_BEEF;
    repeat (2) tick();
    n_tests++;
    if (data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL hold_freeze: data=%h want 12345678", data);
    end
    press_release();
    n_tests++;
    if (page !== 2'd0 || banner !== 1'b0 || data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL hold_discard: page=%0d banner=%b data=%h want 0/0/12345678",
               page, banner, data);
    end
    hold = 1'b0;
    repeat (2) tick();
    n_tests++;
    if (data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL hold_sync: data=%h want 12345678", data);
    end
    tick();
    n_tests++;
    if (data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL hold_release: data=%h want DEADBEEF", data);
    end
  endtask

  task automatic test_hold_banner();
    int nb = 0;
    btn_next = 1'b1;
    repeat (7) tick();
    for (int i = 0; i < 20; i++) begin
      if (banner === 1'b1) nb++;
      if (i == 1) hold = 1'b1;
      tick();
    end
    n_tests++;
    if (nb != 8) begin
      n_fail++;
      $display("FAIL hb_len: cycles=%0d want 8", nb);
    end
    btn_next = 1'b0;
    repeat (20) tick();
    n_tests++;
    if (data !== 32'hFFFF_FFF1 || page !== 2'd1) begin
      n_fail++;
      $display("FAIL hb_keep: data=%h page=%0d want FFFFFFF1/1", data, page);
    end
    hold = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (data !== 32'h1111_0001) begin
      n_fail++;
      $display("FAIL hb_release: data=%h want 11110001", data);
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (5) tick();
    btn_next = 1'b1;
    repeat (7) tick();
    n_tests++;
    if (page2 !== 2'd1 || banner2 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: page=%0d banner=%b want 1/1", page2, banner2);
    end
    btn_next = 1'b0;
    repeat (7) tick();
    btn_next = 1'b1;
    repeat (7) tick();
    n_tests++;
    if (page2 !== 2'd2 || banner2 !== 1'b1 || data2 !== 32'hFFFF_FFF2) begin
      n_fail++;
      $display("FAIL b2b_second: page=%0d banner=%b data=%h want 2/1/FFFFFFF2",
               page2, banner2, data2);
    end
    repeat (23) tick();
    n_tests++;
    if (banner2 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_restart: banner=%b want 1", banner2);
    end
    tick();
    n_tests++;
    if (banner2 !== 1'b0 || data2 !== 32'h2222_0002) begin
      n_fail++;
      $display("FAIL b2b_end: banner=%b data=%h want 0/22220002",
               banner2, data2);
    end
    btn_next = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    int moved = 0;
    btn_next = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (data !== 32'h0 || page !== 2'd0 || banner !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_vals: data=%h page=%0d banner=%b want 0/0/0",
               data, page, banner);
    end
    repeat (2) tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (page !== 2'd0 || banner !== 1'b0) moved++;
    end
    n_tests++;
    if (moved != 0) begin
      n_fail++;
      $display("FAIL rmid_nostep: bad_cycles=%0d want 0", moved);
    end
    btn_next = 1'b0;
    repeat (10) tick();
    btn_next = 1'b1;
    repeat (6) tick();
    n_tests++;
    if (page !== 2'd0) begin
      n_fail++;
      $display("FAIL rmid_early: page=%0d want 0", page);
    end
    tick();
    n_tests++;
    if (page !== 2'd1 || banner !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_fresh: page=%0d banner=%b want 1/1", page, banner);
    end
    btn_next = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_latency();
    test_wrap();
    test_hold();
    test_hold_banner();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_feeder.md
DISPLAY_FEEDER -- requirements
Module: display_feeder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 200000, number of consecutive stable clk cycles for a button level to be accepted (10 ms at 20 MHz).
REQ-002 Parameter BANNER_CYCLES, default 10000000, number of clk cycles the page banner is shown after a page change (0.5 s at 20 MHz).
REQ-003 clk  input  1  20 MHz clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 btn_next  input  1  raw, asynchronous, bouncing pushbutton, 1 = pressed.
REQ-006 hold  input  1  raw slide switch, asynchronous; 1 = freeze displayed value.
REQ-007 src0, src1, src2, src3  input  32 each  source words selectable for display.
REQ-008 data  output  32  registered word driven to the 8-digit seven-segment scanner.
REQ-009 page  output  2  currently selected source index, registered.
REQ-010 banner  output  1  registered; 1 while the page banner is being shown.

Function
REQ-011 btn_next and hold shall each pass through a 2-flop synchronizer before any use; synchronizer flops reset to 0.
REQ-012 The debouncer shall be an FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT and one shared counter, width ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-013 IDLE: synced btn=1 -> PRESS_WAIT, counter cleared.
REQ-014 PRESS_WAIT: btn=0 -> IDLE; btn=1 and counter = DEBOUNCE_CYCLES-1 -> PRESSED and a one-cycle internal next_pulse; otherwise counter increments.
REQ-015 PRESSED: btn=0 -> RELEASE_WAIT, counter cleared; holding the button shall never generate further pulses (no auto-repeat).
REQ-016 RELEASE_WAIT: btn=1 -> PRESSED; btn=0 and counter = DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter increments.
REQ-017 On next_pulse with synced hold=0: page <= page+1 modulo 4 (3 wraps to 0), banner <= 1, banner counter reloaded with BANNER_CYCLES-1.
REQ-018 On next_pulse with synced hold=1 the pulse shall be discarded; page, banner and data are unchanged.
REQ-019 While banner=1, data shall equal {28'hFFFF_FFF, 2'b00, page}; the banner counter decrements each cycle and banner clears in the cycle after it reaches 0.
REQ-020 A next_pulse during an active banner shall advance page and restart the banner count from BANNER_CYCLES-1.
REQ-021 With banner=0 and synced hold=0, data <= src[page] every cycle; latency one clk from src change to data.
REQ-022 With banner=0 and synced hold=1, data shall retain its value.
REQ-023 hold rising while banner=1 shall not cut the banner short; after the banner ends, data retains the banner word until hold falls.
REQ-024 Total latency from a clean btn_next rising edge to page update shall be DEBOUNCE_CYCLES+3 clk cycles (2 sync + debounce + 1 register).

Reset
REQ-025 While rst=0: data=32'h0000_0000, page=0, banner=0, debouncer in IDLE, all counters 0, asynchronously.
REQ-026 After rst returns to 1, data shall show src0 one cycle after synced hold is seen 0 (i.e. within 3 clk cycles).
REQ-027 rst asserted mid-debounce or mid-banner shall abort the operation with no pulse or page change emitted after release until a fresh full press.

Verification (DEBOUNCE_CYCLES=4, BANNER_CYCLES=8)
REQ-028 Reset then src0=32'h1234_5678, hold=0 -> data=32'h1234_5678, page=0, banner=0 within 3 clk cycles.
REQ-029 btn_next bounces 1,0,1,0 each 2 cycles then held 1 for 20 cycles -> exactly one page step to 1, banner=1, data=32'hFFFF_FFF1 for 8 cycles, then data=src1.
REQ-030 Four clean presses from page 3 with release between -> page sequence 0,1,2,3; banner word tracks page; no double steps.
REQ-031 hold=1, src0 changed to 32'hDEAD_BEEF, press btn_next -> data unchanged, page unchanged; hold=0 -> data=32'hDEAD_BEEF next cycle after sync.
REQ-032 Second press while banner active -> page+1, banner restarts, stays 1 for 8 cycles counted from the second pulse.
REQ-033 rst pulsed low during PRESS_WAIT with btn held -> outputs at reset values; no page step until btn released and pressed again.
